// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters are enabled with HAZ_PERF_CNT_EN.
package pipe_ctrl_pkg;

  localparam int NREG_DEF  = 8;
  localparam int REG_W_DEF = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } lmsm_state_e;

  // Opcodes the decoder uses to derive id_is_lmsm and ex_is_load
  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_LM = 4'b1100;
  localparam logic [3:0] OP_SM = 4'b1101;

  function automatic logic is_lmsm_op(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush controls back to it.
// The master side is the hazard controller; the slave side is the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int NREG  = pipe_ctrl_pkg::NREG_DEF,
  parameter int REG_W = pipe_ctrl_pkg::REG_W_DEF,
  parameter int CNT_W = pipe_ctrl_pkg::CNT_W_DEF
) ();

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_lmsm;
  logic [NREG-1:0]  id_lmsm_mask;
  logic             ex_is_load;
  logic             ex_wr_en;
  logic [REG_W-1:0] ex_dest;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_en;
  logic             en_f2d;
  logic             en_d2e;
  logic             en_e2m;
  logic             en_m2w;
  logic             clr_f2d;
  logic             clr_d2e;
  logic             clr_e2m;
  logic             clr_m2w;
  logic [REG_W-1:0] lmsm_reg;
  logic             lmsm_active;
  logic             lmsm_last;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_is_lmsm, id_lmsm_mask, ex_is_load, ex_wr_en, ex_dest,
           ex_branch_taken, mem_busy,
    output pc_en, en_f2d, en_d2e, en_e2m, en_m2w,
           clr_f2d, clr_d2e, clr_e2m, clr_m2w,
           lmsm_reg, lmsm_active, lmsm_last, stall_cycles, flush_count
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_is_lmsm, id_lmsm_mask, ex_is_load, ex_wr_en, ex_dest,
           ex_branch_taken, mem_busy,
    input  pc_en, en_f2d, en_d2e, en_e2m, en_m2w,
           clr_f2d, clr_d2e, clr_e2m, clr_m2w,
           lmsm_reg, lmsm_active, lmsm_last, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lmsm_seq.sv
// Lowest-set-bit encoder for LM/SM masks: returns the index to issue and
// the mask with that bit removed.
module lmsm_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic [NREG-1:0]  mask,
  output logic [REG_W-1:0] index,
  output logic [NREG-1:0]  next_mask,
  output logic             last,
  output logic             any
);

  // Scan from the top so the lowest set bit is the final assignment
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = REG_W'(i);
        any   = 1'b1;
      end
    end
    next_mask = mask & (mask - NREG'(1));
    last      = any && (next_mask == '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with LM/SM sequencing.
// Define HAZ_PERF_CNT_EN to build the stall and flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.master hif
);

  lmsm_state_e      state_q, state_d;
  logic [NREG-1:0]  mask_q, mask_d;

  logic [NREG-1:0]  seq_mask_in;
  logic [REG_W-1:0] seq_index;
  logic [NREG-1:0]  seq_next_mask;
  logic             seq_last;
  logic             seq_any;

  logic             load_use;
  logic             lmsm_start;
  logic             branch_apply;

  logic             pc_en;
  logic             en_f2d, en_d2e, en_e2m, en_m2w;
  logic             clr_f2d, clr_d2e, clr_e2m, clr_m2w;
  logic [REG_W-1:0] lmsm_reg;
  logic             lmsm_active;
  logic             lmsm_last;

  assign seq_mask_in = (state_q == SEQ) ? mask_q : hif.id_lmsm_mask;

  lmsm_seq #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_lmsm_seq (
    .mask      (seq_mask_in),
    .index     (seq_index),
    .next_mask (seq_next_mask),
    .last      (seq_last),
    .any       (seq_any)
  );

  assign load_use = hif.ex_is_load & hif.ex_wr_en & hif.id_valid &
                    ((hif.id_use_rs1 & (hif.id_rs1 == hif.ex_dest)) |
                     (hif.id_use_rs2 & (hif.id_rs2 == hif.ex_dest)));

  assign lmsm_start   = hif.id_valid & hif.id_is_lmsm;
  assign branch_apply = hif.ex_branch_taken & ~hif.mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Memory wait and load-use stalls freeze the sequencer in place
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (hif.mem_busy) begin
      state_d = state_q;
    end else if (hif.ex_branch_taken) begin
      state_d = IDLE;
      mask_d  = '0;
    end else if (load_use) begin
      state_d = state_q;
    end else if (state_q == SEQ) begin
      if (seq_last || !seq_any) begin
        state_d = IDLE;
        mask_d  = '0;
      end else begin
        mask_d  = seq_next_mask;
      end
    end else if (lmsm_start && seq_any && !seq_last) begin
      state_d = SEQ;
      mask_d  = seq_next_mask;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    en_f2d      = 1'b1;
    en_d2e      = 1'b1;
    en_e2m      = 1'b1;
    en_m2w      = 1'b1;
    clr_f2d     = 1'b0;
    clr_d2e     = 1'b0;
    clr_e2m     = 1'b0;
    clr_m2w     = 1'b0;
    lmsm_reg    = '0;
    lmsm_active = 1'b0;
    lmsm_last   = 1'b0;
    if (hif.mem_busy) begin
      pc_en   = 1'b0;
      en_f2d  = 1'b0;
      en_d2e  = 1'b0;
      en_e2m  = 1'b0;
      clr_m2w = 1'b1;
    end else if (hif.ex_branch_taken) begin
      clr_f2d = 1'b1;
      clr_d2e = 1'b1;
    end else if (load_use) begin
      pc_en   = 1'b0;
      en_f2d  = 1'b0;
      clr_d2e = 1'b1;
    end else if ((state_q == SEQ) || (lmsm_start && seq_any)) begin
      lmsm_active = seq_any;
      lmsm_reg    = seq_index;
      lmsm_last   = seq_last;
      if (seq_any && !seq_last) begin
        pc_en  = 1'b0;
        en_f2d = 1'b0;
      end
    end
    // Reset overrides everything so the pipeline registers hold bubbles
    if (!rst_n) begin
      pc_en       = 1'b0;
      en_f2d      = 1'b0;
      en_d2e      = 1'b0;
      en_e2m      = 1'b0;
      en_m2w      = 1'b0;
      clr_f2d     = 1'b1;
      clr_d2e     = 1'b1;
      clr_e2m     = 1'b1;
      clr_m2w     = 1'b1;
      lmsm_reg    = '0;
      lmsm_active = 1'b0;
      lmsm_last   = 1'b0;
    end
  end

  assign hif.pc_en       = pc_en;
  assign hif.en_f2d      = en_f2d;
  assign hif.en_d2e      = en_d2e;
  assign hif.en_e2m      = en_e2m;
  assign hif.en_m2w      = en_m2w;
  assign hif.clr_f2d     = clr_f2d;
  assign hif.clr_d2e     = clr_d2e;
  assign hif.clr_e2m     = clr_e2m;
  assign hif.clr_m2w     = clr_m2w;
  assign hif.lmsm_reg    = lmsm_reg;
  assign hif.lmsm_active = lmsm_active;
  assign hif.lmsm_last   = lmsm_last;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Both counters saturate rather than wrap
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (branch_apply && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
`else
  assign hif.stall_cycles = '0;
  assign hif.flush_count  = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). Drives enable and clr of the four pipeline registers (f2d, d2e, e2m, m2w) and the PC write enable. Resolves memory-wait freezes, taken-branch flushes and load-use stalls. Sequences LM/SM multi-register instructions into one micro-op per cycle.

Parameters:
NREG, 8, number of architectural registers; LM/SM mask width
REG_W, 3, register index width (log2 NREG)
CNT_W, 16, performance counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset
id_valid  in  1  ID holds a valid instruction
id_rs1, id_rs2  in  REG_W  ID source registers
id_use_rs1, id_use_rs2  in  1  source actually read
id_is_lmsm  in  1  ID instruction is LM or SM
id_lmsm_mask  in  NREG  LM/SM register mask
ex_is_load  in  1  EX instruction is a load
ex_wr_en  in  1  EX instruction writes a register
ex_dest  in  REG_W  EX destination register
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_busy  in  1  MEM stage access not complete
pc_en  out  1  PC update enable
en_f2d, en_d2e, en_e2m, en_m2w  out  1  pipeline register enables
clr_f2d, clr_d2e, clr_e2m, clr_m2w  out  1  pipeline register clears (bubble)
lmsm_reg  out  REG_W  register index of current LM/SM micro-op
lmsm_active  out  1  lmsm_reg valid this cycle
lmsm_last  out  1  final micro-op of the LM/SM
stall_cycles  out  CNT_W  stall cycle counter (optional)
flush_count  out  CNT_W  branch flush counter (optional)

Behaviour:
- Reset is asynchronous, active-low (rst_n). While rst_n=0: FSM=IDLE, remaining mask=0, counters=0. All en=0, all clr=1, pc_en=0, lmsm_active=0, lmsm_last=0, lmsm_reg=0 (forced combinationally).
- Outputs are combinational from inputs and registered state. Default is all en=1, all clr=0, pc_en=1.
- Events are evaluated in priority order; the first matching event applies.
- P1 mem_busy=1: pc_en=0; en_f2d=en_d2e=en_e2m=0; en_m2w=1 with clr_m2w=1 (bubble to WB). FSM and remaining mask hold.
- P2 ex_branch_taken=1: clr_f2d=clr_d2e=1; pc_en=1 (target load). FSM forced to IDLE, mask cleared, lmsm_active=0.
- P3 load-use: ex_is_load & ex_wr_en & id_valid & ((id_use_rs1 & id_rs1==ex_dest) | (id_use_rs2 & id_rs2==ex_dest)). Response: pc_en=0, en_f2d=0, clr_d2e=1. Exactly one bubble per hazard; the FSM does not advance.
- P4 LM/SM sequencing. States are IDLE and SEQ.
  - IDLE with id_valid & id_is_lmsm:
    - Lowest set bit of the mask is issued this cycle (lmsm_reg, lmsm_active=1); that bit is cleared to form the remaining mask.
    - If the remaining mask is nonzero: pc_en=0, en_f2d=0, register it, go to SEQ.
    - If it is zero: lmsm_last=1, no stall.
    - Mask=0: lmsm_active=0, instruction passes as a NOP, no stall.
  - SEQ: issue the lowest set bit of the remaining mask and clear it; pc_en=0, en_f2d=0, en_d2e=1. When the issued bit is the last one: lmsm_last=1, pc_en=en_f2d=1, next state IDLE.
  - An LM/SM with popcount k takes exactly k ID cycles (k-1 stall cycles), excluding P1-P3 stalls.
- P3 in SEQ: the decoder presents the micro-op's sources on id_rs1/id_rs2; the check is applied identically and holds the FSM.
- Simultaneous mem_busy and ex_branch_taken: P1 wins; the branch is applied when mem_busy drops.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle that pc_en=0 with rst_n=1.
  - flush_count increments each cycle in which P2 is applied.
  - Both saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state type (IDLE, SEQ); REG_W/NREG defaults; opcode constants for LM, SM and LW used by the decoder's id_is_lmsm/ex_is_load generation.
- One sub-module, lmsm_seq: lowest-set-bit priority encoder plus mask-clear. Inputs: mask. Outputs: index, next_mask, last, any.

Test Plan:
- Load-use: EX load, ex_dest=3; ID id_rs1=3, id_use_rs1=1 -> one cycle pc_en=0, en_f2d=0, clr_d2e=1; next cycle all defaults.
- Branch flush: ex_branch_taken=1 for one cycle -> clr_f2d=clr_d2e=1, pc_en=1; flush_count 0->1 (with HAZ_PERF_CNT_EN).
- LM mask 8'b1010_0100 -> lmsm_reg 2,5,7 on three consecutive cycles; lmsm_last=1 only on 7; pc_en=0 for the first two cycles.
- mem_busy held 3 cycles during SEQ after reg 2 -> all upstream en=0, clr_m2w=1; sequence resumes with 5 then 7.
- Branch taken during SEQ with remaining mask 8'b1000_0000 -> FSM IDLE next cycle, lmsm_active=0, no reg 7 issued.
- rst_n asserted mid-SEQ -> immediately all clr=1, en=0, pc_en=0; after release, FSM IDLE and counters 0.
